// File: rtl/prince_linear_m_iter.sv
// ---------------------------------------------------------------------------
// prince_linear_m_iter
//
// Iterative forward PRINCE linear layer M = SR(M'(x)) for a serialized,
// low-area PRINCE datapath. One 16-bit M' chunk is processed per clock, so a
// block takes four RUN cycles. Both sides use a valid/ready handshake.
// Results are bit-exact with a combinational M' followed by forward ShiftRows.
//
// Optional feature (macro PRINCE_M_INV_EN):
//   When defined, the inv_i port exists and its value is latched at accept.
//   inv_i=1 computes M^-1 = M'(SR^-1(x)) using the same datapath: SR^-1 is
//   applied on load and the final SR is skipped. inv_i=0 computes forward M.
//   Latency and handshake are the same in both modes.
//   When undefined, only forward M is built.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   data_in valid
//   in_ready   out  1   block can accept data_in (IDLE only)
//   data_in    in  64   state; nibble 0 = [63:60] ... nibble 15 = [3:0]
//   inv_i      in   1   inverse select (PRINCE_M_INV_EN only), sampled at accept
//   out_valid  out  1   data_out valid; held until accepted
//   out_ready  in   1   downstream accepts data_out
//   data_out   out 64   M(data_in) (or M^-1 in inverse mode)
// ---------------------------------------------------------------------------
module prince_linear_m_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
`ifdef PRINCE_M_INV_EN
  input  logic        inv_i,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  cnt_reg;
  logic [63:0] work_reg;
  logic [63:0] work_next;
  logic [63:0] sr_work_next;
  logic [63:0] result_next;
  logic [63:0] load_value;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [63:0] data_out_reg;
  logic [15:0] chunk_cur;
  logic [15:0] chunk_new;
  logic        chunk_off;

`ifdef PRINCE_M_INV_EN
  logic        mode_reg;
  logic [63:0] srinv_data_in;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign data_out  = data_out_reg;

  // M-hat on one 16-bit chunk. Nibble i / bit p both count from the MSB.
  // Output nibble j, bit p is the XOR of input bit p of every nibble i except
  // the single one where (i + j + off) mod 4 == p.
  function automatic logic [15:0] mhat(input logic [15:0] c, input logic off);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int p = 0; p < 4; p++) begin
        for (int i = 0; i < 4; i++) begin
          if (((i + j + int'(off)) % 4) != p) begin
            r[15 - 4*j - p] = r[15 - 4*j - p] ^ c[15 - 4*i - p];
          end
        end
      end
    end
    return r;
  endfunction

  // Only the chunk addressed by cnt is transformed each cycle, so a single
  // M-hat instance is shared across all four chunks.
  always_comb begin
    chunk_cur = work_reg[63:48];
    case (cnt_reg)
      2'd0: chunk_cur = work_reg[63:48];
      2'd1: chunk_cur = work_reg[47:32];
      2'd2: chunk_cur = work_reg[31:16];
      2'd3: chunk_cur = work_reg[15:0];
      default: chunk_cur = work_reg[63:48];
    endcase
  end

  // Outer chunks (0,3) use M-hat0, inner chunks (1,2) use M-hat1.
  assign chunk_off = cnt_reg[1] ^ cnt_reg[0];
  assign chunk_new = mhat(chunk_cur, chunk_off);

  always_comb begin
    work_next = work_reg;
    case (cnt_reg)
      2'd0: work_next[63:48] = chunk_new;
      2'd1: work_next[47:32] = chunk_new;
      2'd2: work_next[31:16] = chunk_new;
      2'd3: work_next[15:0]  = chunk_new;
      default: work_next = work_reg;
    endcase
  end

  // ShiftRows is pure wiring: out nibble s = in nibble (5*s mod 16).
  // The last M' chunk and SR are folded into the same edge, so data_out is
  // registered directly from SR(work_next).
  for (genvar gi = 0; gi < 16; gi++) begin : g_sr
    localparam int SR_SRC = (5 * gi) % 16;
    assign sr_work_next[63 - 4*gi -: 4] = work_next[63 - 4*SR_SRC -: 4];
  end

`ifdef PRINCE_M_INV_EN
  // SR^-1: out nibble s = in nibble (13*s mod 16), applied on the way in.
  for (genvar gi = 0; gi < 16; gi++) begin : g_srinv
    localparam int SRI_SRC = (13 * gi) % 16;
    assign srinv_data_in[63 - 4*gi -: 4] = data_in[63 - 4*SRI_SRC -: 4];
  end

  assign load_value  = inv_i ? srinv_data_in : data_in;
  assign result_next = mode_reg ? work_next : sr_work_next;
`else
  assign load_value  = data_in;
  assign result_next = sr_work_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      work_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      data_out_reg  <= '0;
`ifdef PRINCE_M_INV_EN
      mode_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            work_reg     <= load_value;
            cnt_reg      <= 2'd0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
`ifdef PRINCE_M_INV_EN
            mode_reg     <= inv_i;
`endif
          end
        end

        RUN: begin
          work_reg <= work_next;
          cnt_reg  <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            data_out_reg  <= result_next;
          end
        end

        DONE: begin
          // in_ready stays low here so a new accept never overlaps an emit.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= 2'd0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
